// File: rtl/rand_lfsr_param.sv
// rand_lfsr_param: Fibonacci LFSR random source; each start runs STEPS shifts from a new seed or the retained state.
module rand_lfsr_param #(
  parameter int WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS = 6'b110000,
  parameter int STEPS = 6,
  parameter int RES_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(STEPS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, dout_q, dout_d, shifted, seed;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign shifted = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  // an all-zero seed would lock the register, so it is replaced by 1
  assign seed = (data_in == '0) ? WIDTH'(1) : data_in;
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    if (state_q == SHIFT) begin
      lfsr_d = shifted;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(STEPS - 1)) begin
        dout_d = shifted;
        state_d = DONE;
      end
    end else if (start) begin
      lfsr_d = seed_load ? seed : lfsr_q;
      cnt_d = '0;
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= WIDTH'(1);
      cnt_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
    end
  end
  assign data_out = dout_q;
  assign result = dout_q[RES_W-1:0];
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
endmodule
